// File: rtl/jtpopeye_txt_arb_if.sv
// CPU-side bus of the text VRAM arbiter: write/read strobes, read return and flow control.
interface jtpopeye_txt_arb_if;
  logic        cpu_we;
  logic        cpu_rd;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_rd_ok;
  logic        cpu_wait;
  logic        fifo_ovf;

  modport master (output cpu_we, cpu_rd, cpu_addr, cpu_din,
                  input  cpu_dout, cpu_rd_ok, cpu_wait, fifo_ovf);
  modport slave  (input  cpu_we, cpu_rd, cpu_addr, cpu_din,
                  output cpu_dout, cpu_rd_ok, cpu_wait, fifo_ovf);
endinterface

// File: rtl/jtpopeye_txt_arb.sv
// Single-port text char/colour VRAM arbiter: video tile fetch first, CPU writes
// drained from a small FIFO in idle slots, CPU reads held until the FIFO is empty.
module jtpopeye_txt_arb #(
  parameter int       FAW        = 2,
  parameter bit [2:0] SCAN_PHASE = 3'd4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              pxl_cen,
  input  logic [7:0]        H,
  input  logic [7:0]        V,
  jtpopeye_txt_arb_if.slave cpu,
  output logic [9:0]        ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we_chr,
  output logic              ram_we_col,
  input  logic [7:0]        ram_q_chr,
  input  logic [3:0]        ram_q_col,
  output logic [7:0]        scan_chr,
  output logic [3:0]        scan_col,
  output logic              scan_vld
);

  localparam int           DEPTH    = 1 << FAW;
  localparam logic [FAW:0] CNT_FULL = {1'b1, {FAW{1'b0}}};

  // IDLE dispatch | SCAN_RD/SCAN_CAP tile fetch | WR FIFO drain | RD/RD_CAP CPU read
  typedef enum logic [2:0] {IDLE, SCAN_RD, SCAN_CAP, WR, RD, RD_CAP} state_t;
  state_t st;

  // FIFO entry layout: {colour select, cell[9:0], data[7:0]}
  logic [18:0]    fifo_mem [DEPTH];
  logic [FAW-1:0] wr_ptr, rd_ptr;
  logic [FAW:0]   cnt, cnt_nxt;
  logic [18:0]    head;
  logic           full, push, push_drop, pop;

  logic [9:0]  scan_a, scan_a_new;
  logic        scan_pend, scan_now;
  logic [10:0] rd_a;
  logic        rd_pend, rd_set, rd_clr, rd_pend_nxt, rd_unmapped;
  logic        go_scan, go_wr, go_rd;
  logic        unused_v;

  assign unused_v = ^V[2:0];

  always_comb begin
    full        = cnt == CNT_FULL;
    head        = fifo_mem[rd_ptr];
    scan_now    = pxl_cen && H[2:0] == SCAN_PHASE;
    scan_a_new  = {V[7:3], H[7:3] + 5'd1};
    go_scan     = st == IDLE && (scan_now || scan_pend);
    go_wr       = st == IDLE && !go_scan && cnt != '0;
    go_rd       = st == IDLE && !go_scan && cnt == '0 && rd_pend;
    push        = cpu.cpu_we && !cpu.cpu_addr[11] && !full;
    push_drop   = cpu.cpu_we && !cpu.cpu_addr[11] &&  full;
    pop         = go_wr;
    cnt_nxt     = cnt + {{FAW{1'b0}}, push} - {{FAW{1'b0}}, pop};
    rd_set      = cpu.cpu_rd && !rd_pend && !cpu.cpu_addr[11];
    rd_unmapped = cpu.cpu_rd && !rd_pend &&  cpu.cpu_addr[11];
    rd_clr      = st == RD_CAP;
    rd_pend_nxt = (rd_pend && !rd_clr) || rd_set;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cpu.cpu_addr[10:0], cpu.cpu_din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      scan_pend     <= 1'b0;
      scan_a        <= '0;
      rd_pend       <= 1'b0;
      rd_a          <= '0;
      ram_addr      <= '0;
      ram_din       <= '0;
      ram_we_chr    <= 1'b0;
      ram_we_col    <= 1'b0;
      scan_chr      <= '0;
      scan_col      <= '0;
      scan_vld      <= 1'b0;
      cpu.cpu_dout  <= '0;
      cpu.cpu_rd_ok <= 1'b0;
      cpu.cpu_wait  <= 1'b0;
      cpu.fifo_ovf  <= 1'b0;
    end else begin
      ram_we_chr    <= 1'b0;
      ram_we_col    <= 1'b0;
      scan_vld      <= 1'b0;
      cpu.cpu_rd_ok <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nxt;
      if (push_drop) cpu.fifo_ovf <= 1'b1;

      if (rd_set) rd_a <= cpu.cpu_addr[10:0];
      rd_pend      <= rd_pend_nxt;
      cpu.cpu_wait <= (cnt_nxt == CNT_FULL) || rd_pend_nxt;

      // Unmapped reads never touch the RAM and answer on the next clock
      if (rd_unmapped) begin
        cpu.cpu_dout  <= 8'hFF;
        cpu.cpu_rd_ok <= 1'b1;
      end

      if (go_scan) begin
        scan_pend <= 1'b0;
      end else if (scan_now) begin
        scan_pend <= 1'b1;
        scan_a    <= scan_a_new;
      end

      case (st)
        IDLE: begin
          if (go_scan) begin
            st       <= SCAN_RD;
            ram_addr <= scan_now ? scan_a_new : scan_a;
          end else if (go_wr) begin
            st         <= WR;
            ram_addr   <= head[17:8];
            ram_din    <= head[7:0];
            ram_we_chr <= !head[18];
            ram_we_col <=  head[18];
          end else if (go_rd) begin
            st       <= RD;
            ram_addr <= rd_a[9:0];
          end
        end
        SCAN_RD:  st <= SCAN_CAP;
        SCAN_CAP: begin
          scan_chr <= ram_q_chr;
          scan_col <= ram_q_col;
          scan_vld <= 1'b1;
          st       <= IDLE;
        end
        WR:       st <= IDLE;
        RD:       st <= RD_CAP;
        RD_CAP: begin
          cpu.cpu_dout  <= rd_a[10] ? {4'h0, ram_q_col} : ram_q_chr;
          cpu.cpu_rd_ok <= 1'b1;
          st            <= IDLE;
        end
        default:  st <= IDLE;
      endcase
    end
  end

endmodule
